// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates one synchronous byte RAM between MEM byte accesses and a 4-byte little-endian fetch.
// Optional build macro MEMCTRL_RESUME_EN: a preempted fetch resumes at its first uncaptured byte.
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ma_ce_flag,
  input  logic              ma_rw_flag,
  input  logic [31:0]       ma_addr_out,
  input  logic [7:0]        ma_data_out,
  output logic [7:0]        ma_data_in,
  input  logic              if_req,
  input  logic [31:0]       if_pc,
  output logic [31:0]       if_inst,
  output logic              if_done,
  output logic              if_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        issue_idx_q, issue_idx_d;
  logic [2:0]        cap_idx_q, cap_idx_d;
  logic              inflight_valid_q, inflight_valid_d;
  logic [1:0]        inflight_idx_q, inflight_idx_d;
  logic [31:0]       inst_q, inst_d;
  logic              issue_s;
  logic              capture_s;
  logic [ADDR_W-1:0] fetch_addr_s;
  logic              unused_s;

  // Only the low ADDR_W address bits reach the RAM.
  assign unused_s = ^{ma_addr_out[31:ADDR_W], if_pc[31:ADDR_W]};

  assign issue_s      = (state_q == FETCH) && if_req && !ma_ce_flag && (issue_idx_q < 3'd4);
  assign capture_s    = inflight_valid_q;
  assign fetch_addr_s = if_pc[ADDR_W-1:0] + {{(ADDR_W-3){1'b0}}, issue_idx_q};

  assign ma_data_in = ram_din;
  assign if_inst    = inst_q;
  assign if_done    = (state_q == DONE);
  assign if_busy    = (state_q == FETCH);

  // RAM port mux: MEM owns the port whenever it asserts ce.
  always_comb begin
    ram_addr = {ADDR_W{1'b0}};
    ram_wr   = 1'b0;
    ram_dout = 8'd0;
    if (ma_ce_flag) begin
      ram_addr = ma_addr_out[ADDR_W-1:0];
      ram_wr   = ma_rw_flag;
      ram_dout = ma_data_out;
    end else if (issue_s) begin
      ram_addr = fetch_addr_s;
    end else begin
      ram_addr = {ADDR_W{1'b0}};
    end
  end

  // Fetch sequencer next state: issue/capture bookkeeping and MEM preemption.
  always_comb begin
    state_d          = state_q;
    issue_idx_d      = issue_idx_q;
    cap_idx_d        = cap_idx_q;
    inflight_valid_d = 1'b0;
    inflight_idx_d   = inflight_idx_q;
    inst_d           = inst_q;

    // A read launched last cycle always lands, even when MEM has taken the port.
    if (capture_s) begin
      inst_d[8*inflight_idx_q +: 8] = ram_din;
    end else begin
      inst_d = inst_q;
    end

    case (state_q)
      IDLE: begin
        if (if_req && !ma_ce_flag) begin
          state_d     = FETCH;
          issue_idx_d = 3'd0;
          cap_idx_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (!if_req) begin
          state_d = IDLE;
        end else begin
          cap_idx_d = cap_idx_q + {2'b00, capture_s};
          if (ma_ce_flag) begin
`ifdef MEMCTRL_RESUME_EN
            issue_idx_d = cap_idx_d;
`else
            issue_idx_d = 3'd0;
            cap_idx_d   = 3'd0;
`endif
          end else if (issue_s) begin
            issue_idx_d      = issue_idx_q + 3'd1;
            inflight_valid_d = 1'b1;
            inflight_idx_d   = issue_idx_q[1:0];
          end else begin
            issue_idx_d = issue_idx_q;
          end
          if (cap_idx_d == 3'd4) begin
            state_d = DONE;
          end else begin
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial fetch at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      issue_idx_q      <= 3'd0;
      cap_idx_q        <= 3'd0;
      inflight_valid_q <= 1'b0;
      inflight_idx_q   <= 2'd0;
      inst_q           <= 32'd0;
    end else begin
      state_q          <= state_d;
      issue_idx_q      <= issue_idx_d;
      cap_idx_q        <= cap_idx_d;
      inflight_valid_q <= inflight_valid_d;
      inflight_idx_q   <= inflight_idx_d;
      inst_q           <= inst_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed test-plan cases plus randomized MEM/IF traffic vs a behavioural model.
`timescale 1ns/1ps
module tb_mem_ctrl;
  localparam int AW     = 17;
  localparam int RAM_N  = 1 << AW;
  localparam int M_IDLE = 0;
  localparam int M_FETCH = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ma_ce_flag, ma_rw_flag;
  logic [31:0]   ma_addr_out;
  logic [7:0]    ma_data_out, ma_data_in;
  logic          if_req;
  logic [31:0]   if_pc, if_inst;
  logic          if_done, if_busy;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_dout, ram_din;
  logic          ram_wr;
  logic          ram_init;

  logic [7:0] ram     [0:RAM_N-1];
  logic [7:0] ref_mem [0:RAM_N-1];

  int n_cmp = 0, n_err = 0, cyc = 0;
  int m_state, m_run, done_cyc, done_cnt, burst, last_done, c0, fall, start;
  logic [31:0] m_pc, done_inst;
  logic        wr_seen, prev_rd;
  logic [7:0]  prev_rd_data;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ma_ce_flag(ma_ce_flag), .ma_rw_flag(ma_rw_flag), .ma_addr_out(ma_addr_out),
    .ma_data_out(ma_data_out), .ma_data_in(ma_data_in),
    .if_req(if_req), .if_pc(if_pc), .if_inst(if_inst), .if_done(if_done), .if_busy(if_busy),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  function automatic logic [7:0] init_byte(input int a);
    return 8'(a * 37 + (a >> 5) + 3);
  endfunction

  // Synchronous byte RAM with one cycle read latency.
  always @(posedge clk) begin
    if (ram_init) begin
      for (int a = 0; a < RAM_N; a++) ram[a] <= init_byte(a);
    end else if (ram_wr) begin
      ram[ram_addr] <= ram_dout;
    end
    ram_din <= ram[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    logic [16:0] a;
    a = pc[16:0];
    return {ref_mem[a + 17'd3], ref_mem[a + 17'd2], ref_mem[a + 17'd1], ref_mem[a]};
  endfunction

  // Behavioural reference: evaluated once per cycle at the falling edge.
  task automatic model_step();
    logic [16:0] ea;
    logic        ew;
    logic [7:0]  ed;
    logic [16:0] off;
    cyc++;
    if (if_done) begin done_cyc = cyc; done_inst = if_inst; done_cnt++; end
    if (ram_wr) wr_seen = 1'b1;
    if (prev_rd) chk("ma_data_in", 32'(ma_data_in), 32'(prev_rd_data));
    prev_rd      = ma_ce_flag && !ma_rw_flag;
    prev_rd_data = ref_mem[ma_addr_out[16:0]];

    ea = 17'd0; ew = 1'b0; ed = 8'd0;
    if (ma_ce_flag) begin
      ea = ma_addr_out[16:0]; ew = ma_rw_flag; ed = ma_data_out;
      chk("ram_addr_mem", 32'(ram_addr), 32'(ea));
    end else begin
`ifdef MEMCTRL_RESUME_EN
      if (!rst && m_state == M_FETCH && if_req) begin
        off = ram_addr - if_pc[16:0];
        chk("ram_addr_fetch_range", 32'((off <= 17'd3) || (ram_addr == 17'd0)), 32'd1);
      end else begin
        chk("ram_addr_idle", 32'(ram_addr), 32'd0);
      end
`else
      if (!rst && m_state == M_FETCH && if_req && m_run < 4) ea = if_pc[16:0] + 17'(m_run);
      chk("ram_addr", 32'(ram_addr), 32'(ea));
`endif
    end
    chk("ram_wr", 32'(ram_wr), 32'(ew));
    chk("ram_dout", 32'(ram_dout), 32'(ed));

    if (rst) begin
      chk("busy_rst", 32'(if_busy), 32'd0);
      chk("done_rst", 32'(if_done), 32'd0);
      m_state = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: begin
          chk("busy_idle", 32'(if_busy), 32'd0);
          chk("done_idle", 32'(if_done), 32'd0);
          if (if_req && !ma_ce_flag) begin m_state = M_FETCH; m_run = 0; m_pc = if_pc; end
        end
        M_FETCH: begin
`ifdef MEMCTRL_RESUME_EN
          if (if_done) begin
            chk("busy_done", 32'(if_busy), 32'd0);
            chk("inst", if_inst, ref_word(m_pc));
            chk("min_latency", 32'(m_run >= 5), 32'd1);
            m_state = M_IDLE;
          end else begin
            chk("busy_fetch", 32'(if_busy), 32'd1);
            chk("fetch_bound", 32'(m_run < 200), 32'd1);
            if (!if_req) m_state = M_IDLE;
            else m_run++;
          end
`else
          chk("busy_fetch", 32'(if_busy), 32'd1);
          chk("done_fetch", 32'(if_done), 32'd0);
          // Completion needs five consecutive MEM-free cycles; any MEM cycle restarts the count.
          if (!if_req) m_state = M_IDLE;
          else if (ma_ce_flag) m_run = 0;
          else begin
            m_run++;
            if (m_run == 5) m_state = M_DONE;
          end
`endif
        end
        M_DONE: begin
          chk("done", 32'(if_done), 32'd1);
          chk("busy_done", 32'(if_busy), 32'd0);
          chk("inst", if_inst, ref_word(m_pc));
          m_state = M_IDLE;
        end
        default: m_state = M_IDLE;
      endcase
    end
    if (ma_ce_flag && ma_rw_flag) ref_mem[ma_addr_out[16:0]] = ma_data_out;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [31:0] a, input logic [7:0] d);
    ma_ce_flag = 1'b1; ma_rw_flag = 1'b1; ma_addr_out = a; ma_data_out = d;
    tick();
    ma_ce_flag = 1'b0; ma_rw_flag = 1'b0;
  endtask

  task automatic wait_done(input int s);
    for (int k = 0; k < 40 && done_cnt == s; k++) tick();
    if (done_cnt == s) chk("done_timeout", 32'd0, 32'd1);
  endtask

  // Idle cycle with if_req high, then wait for completion; c0 is the first issue cycle.
  task automatic do_fetch(input logic [31:0] pc);
    if_pc = pc; if_req = 1'b1; c0 = cyc + 2; start = done_cnt;
    tick();
    wait_done(start);
    if_req = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    ma_ce_flag = 1'b0; ma_rw_flag = 1'b0; ma_addr_out = 32'd0; ma_data_out = 8'd0;
    if_req = 1'b0; if_pc = 32'd0;
    m_state = M_IDLE; m_run = 0; m_pc = 32'd0; done_cnt = 0; done_cyc = 0; done_inst = 32'd0;
    wr_seen = 1'b0; prev_rd = 1'b0; prev_rd_data = 8'd0; burst = 0;
    for (int a = 0; a < RAM_N; a++) ref_mem[a] = init_byte(a);
    @(posedge clk); #1;
    tick();
    ram_init = 1'b0;
    tick();
    chk("rst_inst", if_inst, 32'd0);
    chk("rst_busy", 32'(if_busy), 32'd0);
    chk("rst_done", 32'(if_done), 32'd0);
    chk("rst_wr", 32'(ram_wr), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_dout", 32'(ram_dout), 32'd0);
    rst = 1'b0;
    tick();

    // Plain fetch
    mem_write(32'h100, 8'h13); mem_write(32'h101, 8'h05);
    mem_write(32'h102, 8'h10); mem_write(32'h103, 8'h00);
    wr_seen = 1'b0;
    do_fetch(32'h100);
    chk("t1_latency", 32'(done_cyc - c0), 32'd5);
    chk("t1_inst", done_inst, 32'h00100513);
    chk("t1_no_wr", 32'(wr_seen), 32'd0);
    tick();

    // MEM store passthrough
    ma_ce_flag = 1'b1; ma_rw_flag = 1'b1; ma_addr_out = 32'h2004; ma_data_out = 8'hAB;
    #1;
    chk("t2_wr", 32'(ram_wr), 32'd1);
    chk("t2_addr", 32'(ram_addr), 32'h2004);
    chk("t2_dout", 32'(ram_dout), 32'hAB);
    tick();
    chk("t2_ram", 32'(ram[17'h2004]), 32'hAB);
    ma_ce_flag = 1'b0; ma_rw_flag = 1'b0;
    tick();

    // MEM load while IF requests: MEM wins
    mem_write(32'h40, 8'h7F);
    ma_ce_flag = 1'b1; ma_rw_flag = 1'b0; ma_addr_out = 32'h40; if_req = 1'b1; if_pc = 32'h100;
    #1;
    chk("t3_addr", 32'(ram_addr), 32'h40);
    tick();
    ma_ce_flag = 1'b0; if_req = 1'b0;
    #1;
    chk("t3_load", 32'(ma_data_in), 32'h7F);
    chk("t3_busy", 32'(if_busy), 32'd0);
    tick();

    // Preemption after the second issue
    mem_write(32'h200, 8'h11); mem_write(32'h201, 8'h22);
    mem_write(32'h202, 8'h33); mem_write(32'h203, 8'h44);
    if_pc = 32'h200; if_req = 1'b1; start = done_cnt;
    tick(); tick(); tick();
    ma_ce_flag = 1'b1; ma_rw_flag = 1'b0; ma_addr_out = 32'h40;
    tick(); tick(); tick();
    ma_ce_flag = 1'b0; fall = cyc + 1;
    #1;
`ifdef MEMCTRL_RESUME_EN
    chk("t4_reissue", 32'(ram_addr), 32'h202);
`else
    chk("t4_reissue", 32'(ram_addr), 32'h200);
`endif
    wait_done(start);
    if_req = 1'b0;
`ifdef MEMCTRL_RESUME_EN
    chk("t4_latency", 32'(done_cyc - fall), 32'd3);
`else
    chk("t4_latency", 32'(done_cyc - fall), 32'd5);
`endif
    chk("t4_inst", done_inst, 32'h44332211);
    tick();

    // Abort after two issues
    if_pc = 32'h100; if_req = 1'b1;
    tick(); tick(); tick();
    if_req = 1'b0; start = done_cnt;
    #1;
    chk("t5_busy_last", 32'(if_busy), 32'd1);
    tick();
    chk("t5_busy_idle", 32'(if_busy), 32'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("t5_no_done", 32'(done_cnt - start), 32'd0);

    // Asynchronous reset mid-fetch, then a clean fetch
    if_pc = 32'h100; if_req = 1'b1;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_busy", 32'(if_busy), 32'd0);
    chk("t6_done", 32'(if_done), 32'd0);
    chk("t6_wr", 32'(ram_wr), 32'd0);
    chk("t6_inst", if_inst, 32'd0);
    tick();
    rst = 1'b0;
    do_fetch(32'h100);
    chk("t6_latency", 32'(done_cyc - c0), 32'd5);
    chk("t6_inst_after", done_inst, 32'h00100513);
    tick();

    // Address wrap at 2^ADDR_W with nonzero upper pc bits
    mem_write(32'h1FFFE, 8'hA1); mem_write(32'h1FFFF, 8'hB2);
    mem_write(32'h0, 8'hC3); mem_write(32'h1, 8'hD4);
    do_fetch(32'h8001FFFE);
    chk("t7_latency", 32'(done_cyc - c0), 32'd5);
    chk("t7_inst", done_inst, 32'hD4C3B2A1);
    tick();

    // Randomized MEM bursts, fetches, back-to-back fetches and aborts
    last_done = done_cnt;
    for (int n = 0; n < 3000; n++) begin
      if (burst > 0) begin
        ma_ce_flag = 1'b1; burst--;
      end else if ($urandom_range(0, 99) < 12) begin
        ma_ce_flag = 1'b1; burst = $urandom_range(0, 2);
      end else begin
        ma_ce_flag = 1'b0;
      end
      ma_rw_flag  = 1'($urandom_range(0, 1));
      ma_data_out = 8'($urandom);
      if (ma_ce_flag && ma_rw_flag) ma_addr_out = {15'($urandom), 17'h02000 + 17'($urandom_range(0, 255))};
      else ma_addr_out = $urandom;
      if (!if_req) begin
        if ($urandom_range(0, 99) < 40) begin
          if_req = 1'b1;
          if_pc  = {15'($urandom), 17'h00100 + 17'($urandom_range(0, 252))};
        end
      end else if (m_state == M_FETCH && $urandom_range(0, 99) < 2) begin
        if_req = 1'b0;
      end else if (done_cnt != last_done && $urandom_range(0, 1) == 1) begin
        if_req = 1'b0;
      end
      last_done = done_cnt;
      tick();
    end
    ma_ce_flag = 1'b0; if_req = 1'b0;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
